// File: rtl/gpio_uart_tx_if.sv
// Write-strobe bus from the processor GPIO port into the UART stage, plus line/status.
// Handshake: we_gpio is a one-cycle valid with no ready; a write that finds the FIFO full
// (and no pop that cycle) is dropped and latched in overflow instead of stalling the source.
interface gpio_uart_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] gpio_o;
    logic                  we_gpio;
    logic                  tx;
    logic                  busy;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  overflow;

    modport master (
        output gpio_o, we_gpio,
        input  tx, busy, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  gpio_o, we_gpio,
        output tx, busy, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/gpio_uart_tx.sv
// GPIO write strobe -> byte FIFO -> 8N1 UART transmitter.
// Each write pushes gpio_o[7:0]; the FSM drains the FIFO one frame at a time on tx.
module gpio_uart_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 16
) (
    input  logic             clk,
    input  logic             rst,
    gpio_uart_tx_if.slave    bus,
    output logic [1:0]       dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [DIV_W-1:0]   baud, baud_next;
    logic [2:0]         idx, idx_next;
    logic [7:0]         shift, shift_next;
    logic               tx_q, tx_next;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, empty, push, pop;
    logic               overflow_q;

    // Only the low byte is transmitted.
    logic unused_gpio_hi;
    assign unused_gpio_hi = ^bus.gpio_o[DATA_WIDTH-1:8];

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = (state == IDLE) && !empty;
    assign push  = bus.we_gpio && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.gpio_o[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.we_gpio && !push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_next;
            baud  <= baud_next;
            idx   <= idx_next;
            shift <= shift_next;
            tx_q  <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud;
        idx_next   = idx;
        shift_next = shift;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (!empty) begin
                    state_next = START;
                    shift_next = mem[rd_ptr];
                end
            end
            START: begin
                if (baud == DIV_W'(CLK_DIV - 1)) begin
                    state_next = DATA;
                    baud_next  = '0;
                    idx_next   = '0;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud == DIV_W'(CLK_DIV - 1)) begin
                    baud_next = '0;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        shift_next = {1'b0, shift[7:1]};
                        idx_next   = idx + 1'b1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: begin
                if (baud == DIV_W'(CLK_DIV - 1)) begin
                    state_next = IDLE;
                    baud_next  = '0;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
        endcase
        // tx is registered from the next state so the line changes on the same edge as the state.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = (state != IDLE) || !empty;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.overflow   = overflow_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx: a negedge UART monitor decodes frames and pops the
// expected-byte queue that the stimulus steps fill.
module tb_gpio_uart_tx;
  localparam int DIV = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  gpio_uart_tx_if #(.DATA_WIDTH(32)) bus ();

  gpio_uart_tx #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(4),
    .CLK_DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  int         frame_starts[$];
  int         cyc = 0;
  bit         mon_active = 1'b0;
  int         mon_pos = 0;
  int         mon_bit = 0;
  logic [7:0] mon_byte = '0;
  logic [7:0] exp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_write(input logic [7:0] b);
    bus.gpio_o  = {24'h0, b};
    bus.we_gpio = 1'b1;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((bus.busy || mon_active) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < limit), 1);
  endtask

  // scoreboard monitor: frame timing relative to the first low sample
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (bus.tx === 1'b0) begin
        mon_active = 1'b1;
        mon_pos = 0;
        frame_starts.push_back(cyc);
      end
    end else begin
      mon_pos++;
      if (mon_pos < DIV) begin
        check("start_bit", bus.tx, 0);
      end else if (mon_pos < 9 * DIV) begin
        mon_bit = (mon_pos - DIV) / DIV;
        if ((mon_pos - DIV) % DIV == 0) mon_byte[mon_bit] = bus.tx;
        else check("data_bit_stable", bus.tx, mon_byte[mon_bit]);
      end else begin
        check("stop_bit", bus.tx, 1);
        if (mon_pos == FRAME - 1) begin
          mon_active = 1'b0;
          check("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("frame_byte", mon_byte, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int lows;

    // reset
    rst = 1'b1;
    bus.we_gpio = 1'b0;
    bus.gpio_o = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_full", bus.fifo_full, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // single write 0xA5
    drive_write(8'hA5);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    bus.we_gpio = 1'b0;
    check("single_not_empty", bus.fifo_empty, 0);
    check("single_busy", bus.busy, 1);
    check("single_tx_still_high", bus.tx, 1);
    @(negedge clk);
    n = 1;
    check("single_start_latency", bus.tx, 0);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("single_busy_cycles", n, 41);
    check("single_drained", exp_q.size(), 0);

    // burst 0x41..0x43
    base = frame_starts.size();
    for (int i = 0; i < 3; i++) begin
      drive_write(8'(8'h41 + i));
      exp_q.push_back(8'(8'h41 + i));
      @(negedge clk);
    end
    bus.we_gpio = 1'b0;
    wait_drain(400);
    check("burst_frames", frame_starts.size() - base, 3);
    check("burst_gap1", frame_starts[base + 1] - frame_starts[base], FRAME + 1);
    check("burst_gap2", frame_starts[base + 2] - frame_starts[base + 1], FRAME + 1);
    check("burst_no_overflow", bus.overflow, 0);
    check("burst_drained", exp_q.size(), 0);

    // overflow: 0x10..0x15 from idle, 0x15 dropped
    for (int i = 0; i < 6; i++) begin
      drive_write(8'(8'h10 + i));
      if (i < 5) exp_q.push_back(8'(8'h10 + i));
      @(negedge clk);
      if (i == 4) begin
        check("ovf_full_at_fifth", bus.fifo_full, 1);
        check("ovf_not_yet", bus.overflow, 0);
      end
    end
    bus.we_gpio = 1'b0;
    check("ovf_set", bus.overflow, 1);
    check("ovf_still_full", bus.fifo_full, 1);
    wait_drain(600);
    check("ovf_sticky", bus.overflow, 1);
    check("ovf_empty_after", bus.fifo_empty, 1);
    check("ovf_drained", exp_q.size(), 0);

    // simultaneous push and pop while full
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("pp_ovf_cleared", bus.overflow, 0);
    for (int i = 0; i < 5; i++) begin
      drive_write(8'(8'h31 + i));
      exp_q.push_back(8'(8'h31 + i));
      @(negedge clk);
    end
    bus.we_gpio = 1'b0;
    check("pp_full", bus.fifo_full, 1);
    n = 0;
    while (dbg_state != 2'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pp_reached_idle", 32'(n < 200), 1);
    check("pp_full_at_pop", bus.fifo_full, 1);
    drive_write(8'h77);
    exp_q.push_back(8'h77);
    @(negedge clk);
    bus.we_gpio = 1'b0;
    check("pp_full_kept", bus.fifo_full, 1);
    check("pp_no_overflow", bus.overflow, 0);
    check("pp_started", dbg_state, 1);
    wait_drain(700);
    check("pp_no_overflow_end", bus.overflow, 0);
    check("pp_drained", exp_q.size(), 0);

    // reset during bit 3 of 0x5A with two bytes queued
    drive_write(8'h5A);
    exp_q.push_back(8'h5A);
    @(negedge clk);
    drive_write(8'h01);
    exp_q.push_back(8'h01);
    @(negedge clk);
    drive_write(8'h02);
    exp_q.push_back(8'h02);
    @(negedge clk);
    bus.we_gpio = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_in_data", dbg_state, 2);
    #1 rst = 1'b1;
    #1;
    check("mid_tx_high", bus.tx, 1);
    check("mid_empty", bus.fifo_empty, 1);
    check("mid_busy", bus.busy, 0);
    check("mid_state", dbg_state, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = frame_starts.size();
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) lows++;
    end
    check("mid_line_quiet", lows, 0);
    check("mid_no_frame", frame_starts.size() - base, 0);
    drive_write(8'h3C);
    exp_q.push_back(8'h3C);
    @(negedge clk);
    bus.we_gpio = 1'b0;
    wait_drain(200);
    check("post_rst_frame", frame_starts.size() - base, 1);
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
